// File: rtl/data_ram_responder_pkg.sv
// Shared types for the MEM-stage data-RAM responder: register width and FSM state encodings.
package data_ram_responder_pkg;

   localparam int REG_WIDTH = 32;
   localparam int SEL_W     = REG_WIDTH / 8;

   typedef enum logic [1:0] {
      DRAM_IDLE   = 2'd0,
      DRAM_ACCESS = 2'd1,
      DRAM_DONE   = 2'd2
   } dram_state_t;

endpackage

// File: rtl/data_ram_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-RAM responder (slave).
interface data_ram_responder_if;
   import data_ram_responder_pkg::*;

   // Handshake: ram_en_i is the request valid. The master holds every request field stable
   // while pause_ram_o=1; the response word on ram_data_o is valid in the cycle pause_ram_o
   // falls with ram_en_i still high. Dropping ram_en_i while paused withdraws the request.
   logic                 ram_en_i;
   logic                 mem_write_en_i;
   logic [REG_WIDTH-1:0] mem_addr_i;
   logic [REG_WIDTH-1:0] store_data_i;
   logic [SEL_W-1:0]     mem_select_i;
   logic [REG_WIDTH-1:0] ram_data_o;
   logic                 pause_ram_o;

   modport master (
      output ram_en_i, mem_write_en_i, mem_addr_i, store_data_i, mem_select_i,
      input  ram_data_o, pause_ram_o
   );

   modport slave (
      input  ram_en_i, mem_write_en_i, mem_addr_i, store_data_i, mem_select_i,
      output ram_data_o, pause_ram_o
   );

endinterface

// File: rtl/data_ram_responder_byte_array.sv
// Word-organised on-chip array with per-byte write enables and a registered read port;
// a write access returns zero so the response word is always defined.
module data_ram_responder_byte_array
   import data_ram_responder_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 we,
   input  logic [ADDR_W-1:0]    addr,
   input  logic [SEL_W-1:0]     be,
   input  logic [REG_WIDTH-1:0] wdata,
   output logic [REG_WIDTH-1:0] rdata
);

   logic [REG_WIDTH-1:0] mem [2**ADDR_W];

   // Contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (en && we) begin
         for (int k = 0; k < SEL_W; k++) begin
            if (be[k]) mem[addr][k*8 +: 8] <= wdata[k*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (en) begin
         rdata <= we ? '0 : mem[addr];
      end
   end

endmodule

// File: rtl/data_ram_responder.sv
// Responder end of the MEM-stage data-RAM port: latches a request, waits WAIT_CYCLES,
// performs the access on the completion edge and presents the word for one DONE cycle.
module data_ram_responder
   import data_ram_responder_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   data_ram_responder_if.slave  bus,
   output dram_state_t          dbg_state
);

   localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
   localparam logic [3:0] WAIT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

   dram_state_t          state;
   logic [3:0]           wait_cnt;
   logic [ADDR_W-1:0]    lat_idx;
   logic                 lat_we;
   logic [SEL_W-1:0]     lat_sel;
   logic [REG_WIDTH-1:0] lat_data;

   logic [ADDR_W-1:0]    req_idx;
   logic                 acc_en;
   logic                 acc_we;
   logic [ADDR_W-1:0]    acc_idx;
   logic [SEL_W-1:0]     acc_sel;
   logic [REG_WIDTH-1:0] acc_data;
   logic                 unused_addr_bits;

   // High address bits alias and the byte offset was already checked upstream.
   assign req_idx          = bus.mem_addr_i[ADDR_W+1:2];
   assign unused_addr_bits = ^{bus.mem_addr_i[REG_WIDTH-1:ADDR_W+2], bus.mem_addr_i[1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= DRAM_IDLE;
         wait_cnt <= '0;
         lat_idx  <= '0;
         lat_we   <= 1'b0;
         lat_sel  <= '0;
         lat_data <= '0;
      end else begin
         case (state)
            DRAM_IDLE: begin
               if (bus.ram_en_i) begin
                  lat_idx  <= req_idx;
                  lat_we   <= bus.mem_write_en_i;
                  lat_sel  <= bus.mem_select_i;
                  lat_data <= bus.store_data_i;
                  wait_cnt <= WAIT_INIT;
                  state    <= NO_WAIT ? DRAM_DONE : DRAM_ACCESS;
               end
            end
            DRAM_ACCESS: begin
               if (!bus.ram_en_i) begin
                  state <= DRAM_IDLE;
               end else if (wait_cnt == 4'd0) begin
                  state <= DRAM_DONE;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            DRAM_DONE: state <= DRAM_IDLE;
            default:   state <= DRAM_IDLE;
         endcase
      end
   end

   // With no wait states the access happens on the accepting edge, so it must use the live request.
   always_comb begin
      acc_en   = 1'b0;
      acc_we   = lat_we;
      acc_idx  = lat_idx;
      acc_sel  = lat_sel;
      acc_data = lat_data;
      if (state == DRAM_IDLE) begin
         acc_en   = NO_WAIT && bus.ram_en_i;
         acc_we   = bus.mem_write_en_i;
         acc_idx  = req_idx;
         acc_sel  = bus.mem_select_i;
         acc_data = bus.store_data_i;
      end else if (state == DRAM_ACCESS) begin
         acc_en = bus.ram_en_i && (wait_cnt == 4'd0);
      end
      if (rst) acc_en = 1'b0;
   end

   data_ram_responder_byte_array #(.ADDR_W(ADDR_W)) u_array (
      .clk   (clk),
      .rst   (rst),
      .en    (acc_en),
      .we    (acc_we),
      .addr  (acc_idx),
      .be    (acc_sel),
      .wdata (acc_data),
      .rdata (bus.ram_data_o)
   );

   assign bus.pause_ram_o = bus.ram_en_i && (state != DRAM_DONE);
   assign dbg_state       = state;

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed plus randomized checks of data_ram_responder at 0, 1 and 3 wait states
// against a word-level memory model.
module tb_data_ram_responder;
   import data_ram_responder_pkg::*;

   logic clk;
   logic rst1, rst3, rst0;
   dram_state_t st1, st3, st0;
   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   logic [31:0] model_mem [int];

   data_ram_responder_if bus1 ();
   data_ram_responder_if bus3 ();
   data_ram_responder_if bus0 ();

   data_ram_responder #(.ADDR_W(12), .WAIT_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst1), .bus(bus1), .dbg_state(st1));
   data_ram_responder #(.ADDR_W(6), .WAIT_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst3), .bus(bus3), .dbg_state(st3));
   data_ram_responder #(.ADDR_W(6), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst0), .bus(bus0), .dbg_state(st0));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int wait_of(input int inst);
      return (inst == 1) ? 1 : (inst == 3) ? 3 : 0;
   endfunction

   function automatic int key_of(input int inst, input logic [31:0] addr);
      int idx;
      idx = (inst == 1) ? int'(addr[13:2]) : int'(addr[7:2]);
      return inst * 65536 + idx;
   endfunction

   function automatic logic [31:0] model_read(input int inst, input logic [31:0] addr);
      return model_mem[key_of(inst, addr)];
   endfunction

   task automatic model_write(input int inst, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] sel);
      logic [31:0] w;
      w = model_mem.exists(key_of(inst, addr)) ? model_mem[key_of(inst, addr)] : 32'h0;
      for (int k = 0; k < 4; k++) if (sel[k]) w[k*8 +: 8] = data[k*8 +: 8];
      model_mem[key_of(inst, addr)] = w;
   endtask

   task automatic set_req(input int inst, input logic en, input logic we,
                          input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
      case (inst)
         1: begin
            bus1.ram_en_i = en; bus1.mem_write_en_i = we; bus1.mem_addr_i = addr;
            bus1.store_data_i = data; bus1.mem_select_i = sel;
         end
         3: begin
            bus3.ram_en_i = en; bus3.mem_write_en_i = we; bus3.mem_addr_i = addr;
            bus3.store_data_i = data; bus3.mem_select_i = sel;
         end
         default: begin
            bus0.ram_en_i = en; bus0.mem_write_en_i = we; bus0.mem_addr_i = addr;
            bus0.store_data_i = data; bus0.mem_select_i = sel;
         end
      endcase
   endtask

   task automatic set_garbage(input int inst, input logic en);
      set_req(inst, en, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
   endtask

   function automatic logic get_pause(input int inst);
      case (inst)
         1:       return bus1.pause_ram_o;
         3:       return bus3.pause_ram_o;
         default: return bus0.pause_ram_o;
      endcase
   endfunction

   function automatic logic [31:0] get_data(input int inst);
      case (inst)
         1:       return bus1.ram_data_o;
         3:       return bus3.ram_data_o;
         default: return bus0.ram_data_o;
      endcase
   endfunction

   function automatic logic [1:0] get_state(input int inst);
      case (inst)
         1:       return st1;
         3:       return st3;
         default: return st0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the responder idle; returns at a negedge with it idle again.
   task automatic txn(input int inst, input logic we, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] sel, input string tag);
      logic [31:0] exp_d;
      int w;
      w = wait_of(inst);
      exp_d = we ? 32'h0 : model_read(inst, addr);
      set_req(inst, 1'b1, we, addr, data, sel);
      #1;
      check({tag, ".pause_first"}, 32'(get_pause(inst)), 32'd1);
      for (int c = 1; c <= w; c++) begin
         @(negedge clk);
         set_garbage(inst, 1'b1);
         #1;
         check({tag, ".pause_wait"}, 32'(get_pause(inst)), 32'd1);
         check({tag, ".state_wait"}, 32'(get_state(inst)), 32'(DRAM_ACCESS));
      end
      @(negedge clk);
      #1;
      check({tag, ".state_done"}, 32'(get_state(inst)), 32'(DRAM_DONE));
      check({tag, ".pause_done"}, 32'(get_pause(inst)), 32'd0);
      check({tag, ".data"}, get_data(inst), exp_d);
      if (we) model_write(inst, addr, data, sel);
      set_garbage(inst, 1'b0);
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] held;
      rst1 = 1'b1; rst3 = 1'b1; rst0 = 1'b1;
      set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      set_req(3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst1 = 1'b0; rst3 = 1'b0; rst0 = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) continue;
         check("reset.state", 32'(get_state(i)), 32'(DRAM_IDLE));
         check("reset.pause", 32'(get_pause(i)), 32'd0);
         check("reset.data", get_data(i), 32'h0);
      end
      @(negedge clk);

      // Full-word store then load, one wait state
      txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, "t1.store");
      txn(1, 1'b0, 32'h10, 32'h0, 4'b0000, "t1.load");
      check("t1.value", get_data(1), 32'hDEADBEEF);
      // Single-lane store over a known word
      txn(1, 1'b1, 32'h10, 32'h11223344, 4'b1111, "t2.base");
      txn(1, 1'b1, 32'h11, 32'hAAAAAAAA, 4'b0100, "t2.byte");
      txn(1, 1'b0, 32'h10, 32'h0, 4'b1111, "t2.load");
      check("t2.value", get_data(1), 32'h11AA3344);
      // Empty byte mask writes nothing
      txn(1, 1'b1, 32'h12, 32'h55555555, 4'b0000, "t3.nosel");
      txn(1, 1'b0, 32'h10, 32'h0, 4'b0000, "t3.load");
      check("t3.value", get_data(1), 32'h11AA3344);

      // Flush during a three-wait-state store
      txn(3, 1'b1, 32'h20, 32'hCAFEF00D, 4'b1111, "t4.init");
      set_req(3, 1'b1, 1'b1, 32'h20, 32'h01234567, 4'b1111);
      @(negedge clk);
      set_req(3, 1'b0, 1'b1, 32'h20, 32'h01234567, 4'b1111);
      #1;
      check("t4.pause_drop", 32'(get_pause(3)), 32'd0);
      @(negedge clk);
      #1;
      check("t4.state_idle", 32'(get_state(3)), 32'(DRAM_IDLE));
      repeat (4) @(negedge clk);
      txn(3, 1'b0, 32'h20, 32'h0, 4'b0000, "t4.load");
      check("t4.value", get_data(3), 32'hCAFEF00D);

      // Reset in the middle of a pending store
      set_req(3, 1'b1, 1'b1, 32'h20, 32'h89ABCDEF, 4'b1111);
      @(negedge clk);
      rst3 = 1'b1;
      set_req(3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      #1;
      check("t5.state", 32'(get_state(3)), 32'(DRAM_IDLE));
      check("t5.pause", 32'(get_pause(3)), 32'd0);
      check("t5.data", get_data(3), 32'h0);
      rst3 = 1'b0;
      repeat (4) @(negedge clk);
      txn(3, 1'b0, 32'h20, 32'h0, 4'b0000, "t5.load");
      check("t5.value", get_data(3), 32'hCAFEF00D);

      // Zero wait states, back-to-back loads
      txn(0, 1'b1, 32'h0, 32'h0BADF00D, 4'b1111, "t6.st0");
      txn(0, 1'b1, 32'h4, 32'h600DCAFE, 4'b1111, "t6.st4");
      txn(0, 1'b0, 32'h0, 32'h0, 4'b1111, "t6.ld0");
      held = get_data(0);
      txn(0, 1'b0, 32'h4, 32'h0, 4'b1111, "t6.ld4");
      check("t6.value0", held, 32'h0BADF00D);
      check("t6.value4", get_data(0), 32'h600DCAFE);
      // Response word holds through idle
      repeat (3) @(negedge clk);
      #1;
      check("t6.hold", get_data(0), 32'h600DCAFE);
      @(negedge clk);

      // Randomized traffic over a small word pool with aliased address bits
      for (int i = 0; i < 8; i++) begin
         a = 32'((100 + i) << 2);
         txn(1, 1'b1, a, $urandom, 4'b1111, "rnd.init");
      end
      for (int n = 0; n < 40; n++) begin
         a = ($urandom & 32'hFFFFC003) | 32'((100 + $urandom_range(0, 7)) << 2);
         txn(1, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), "rnd");
      end
      for (int n = 0; n < 16; n++) begin
         a = 32'($urandom_range(0, 1) << 2) | ($urandom & 32'hFFFFFF03);
         txn(0, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), "rnd0");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
